// File: rtl/vm_vend_ctrl.sv
// Vending controller: coin credit, 8-entry stock table, CHECK/DISPENSE/REFUSE flow.
// Optional refund input is enabled by defining VM_REFUND_EN.
module vm_vend_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  coins,
  input  logic [2:0]  buttons,
  input  logic        select,
  input  logic [2:0]  item,
  input  logic [3:0]  count,
  input  logic [7:0]  cost,
  input  logic        valid,
`ifdef VM_REFUND_EN
  input  logic        refund,
`endif
  output logic [2:0]  product,
  output logic [1:0]  status,
  output logic [15:0] balance,
  output logic [7:0]  info
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    COLLECT  = 3'd1,
    CHECK    = 3'd2,
    DISPENSE = 3'd3,
    REFUSE   = 3'd4
  } state_t;

  state_t state, state_nxt;

  logic [3:0]  cnt_tbl [8];
  logic [7:0]  cst_tbl [8];
  logic [2:0]  sel_q;
  logic [1:0]  why_q;

  logic        refund_req;
  logic        accepting;
  logic [7:0]  coin_val;
  logic [16:0] bal_sum;
  logic [15:0] bal_sat;
  logic [3:0]  tbl_cnt;
  logic [7:0]  tbl_cst;
  logic [15:0] bal_after_vend;

`ifdef VM_REFUND_EN
  assign refund_req = refund;
`else
  assign refund_req = 1'b0;
`endif

  assign accepting = (state == IDLE) || (state == COLLECT);

  always_comb begin
    coin_val = '0;
    case (coins)
      2'b01:   coin_val = 8'd5;
      2'b10:   coin_val = 8'd10;
      2'b11:   coin_val = 8'd25;
      default: coin_val = '0;
    endcase
  end

  assign bal_sum        = {1'b0, balance} + {9'b0, coin_val};
  assign bal_sat        = bal_sum[16] ? '1 : bal_sum[15:0];
  assign tbl_cnt        = cnt_tbl[sel_q];
  assign tbl_cst        = cst_tbl[sel_q];
  assign bal_after_vend = balance - {8'b0, tbl_cst};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, COLLECT: begin
        if (refund_req)       state_nxt = IDLE;
        else if (select)      state_nxt = CHECK;
        else if (coins != '0) state_nxt = COLLECT;
      end
      CHECK: begin
        if (tbl_cnt == '0 || balance < {8'b0, tbl_cst}) state_nxt = REFUSE;
        else                                            state_nxt = DISPENSE;
      end
      DISPENSE: state_nxt = (bal_after_vend != '0) ? COLLECT : IDLE;
      REFUSE:   state_nxt = (balance != '0) ? COLLECT : IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      product <= '0;
      status  <= '0;
      balance <= '0;
      info    <= '0;
      sel_q   <= '0;
      why_q   <= '0;
    end else begin
      case (state)
        IDLE, COLLECT: begin
          if (refund_req) begin
            info    <= (balance > 16'd255) ? 8'hFF : balance[7:0];
            balance <= '0;
            status  <= '0;
          end else begin
            if (coins != '0) balance <= bal_sat;
            if (select)      sel_q   <= buttons;
          end
        end
        CHECK: why_q <= (tbl_cnt == '0) ? 2'b10 : 2'b11;
        DISPENSE: begin
          product <= sel_q;
          status  <= 2'b01;
          balance <= bal_after_vend;
          info    <= {4'b0, tbl_cnt - 4'd1};
        end
        REFUSE: begin
          product <= sel_q;
          status  <= why_q;
          info    <= tbl_cst;
        end
        default: ;
      endcase
    end
  end

  // Supplier write is applied after the decrement so it wins on the same entry.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < 8; i++) begin
        cnt_tbl[i] <= '0;
        cst_tbl[i] <= '0;
      end
    end else begin
      if (state == DISPENSE) cnt_tbl[sel_q] <= tbl_cnt - 4'd1;
      if (valid) begin
        cnt_tbl[item] <= count;
        cst_tbl[item] <= cost;
      end
    end
  end

  logic unused_ok;
  assign unused_ok = accepting;

endmodule

// File: doc/vm_vend_ctrl.md
VM_VEND_CTRL -- requirements
Module: vm_vend_ctrl

Interface
REQ-001 The block SHALL have the port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-002 The block SHALL have the port rst, input, 1 bit: reset, asynchronous assert, active-low.
REQ-003 The block SHALL have the port coins, input, 2 bits: 00 none, 01 = 5, 10 = 10, 11 = 25 units, one coin per cycle.
REQ-004 The block SHALL have the port buttons, input, 3 bits: item index, sampled only with select.
REQ-005 The block SHALL have the port select, input, 1 bit: purchase request for buttons.
REQ-006 The block SHALL have the ports item (input, 3 bits), count (input, 4 bits), cost (input, 8 bits) and valid (input, 1 bit): a supplier write of count and cost into stock entry item when valid=1.
REQ-007 The block SHALL have the port product, output, 3 bits: index of the last vended or refused item.
REQ-008 The block SHALL have the port status, output, 2 bits: 00 idle/none, 01 vended, 10 out of stock, 11 insufficient funds.
REQ-009 The block SHALL have the port balance, output, 16 bits: current credit.
REQ-010 The block SHALL have the port info, output, 8 bits: remaining count after a vend, item cost after a refusal.

Function
REQ-011 The block SHALL hold an 8-entry stock table, each entry a 4-bit count and an 8-bit cost.
REQ-012 The FSM states SHALL be IDLE, COLLECT, CHECK, DISPENSE and REFUSE.
REQ-013 In IDLE and COLLECT, a nonzero coin SHALL add its value to balance next cycle, saturating at 16'hFFFF; a nonzero coin in IDLE SHALL move the FSM to COLLECT.
REQ-014 In IDLE and COLLECT, select=1 SHALL latch buttons and move the FSM to CHECK; a coin in the same cycle SHALL still be credited.
REQ-015 Coins and select SHALL be ignored in CHECK, DISPENSE and REFUSE.
REQ-016 CHECK (1 cycle) SHALL go to REFUSE with status=10 if the entry count is 0, else to REFUSE with status=11 if balance < zero-extended cost, else to DISPENSE.
REQ-017 CHECK SHALL use the table contents as registered at the start of the CHECK cycle.
REQ-018 DISPENSE (1 cycle) SHALL register product=item, status=01, balance -= cost, count -= 1 and info = the new count.
REQ-019 REFUSE (1 cycle) SHALL register product=item and info=cost, and SHALL leave balance unchanged.
REQ-020 From DISPENSE or REFUSE, the FSM SHALL go to COLLECT if the resulting balance is nonzero, else to IDLE.
REQ-021 The latency from select to a vend result SHALL be 3 clocks (select edge -> CHECK -> DISPENSE -> outputs registered).
REQ-022 product, status and info SHALL hold until the next DISPENSE, REFUSE or refund.
REQ-023 A supplier write SHALL overwrite count and cost in any state and take effect next cycle.
REQ-024 A supplier write to the entry being decremented in DISPENSE SHALL take priority, so the stored count equals the supplier count with no decrement.
REQ-025 A DISPENSE that reads cost while a supplier write to the same entry occurs SHALL charge the old cost.

Reset
REQ-026 When rst=0, the block SHALL asynchronously set the FSM to IDLE, product=0, status=00, balance=0 and info=0, and SHALL clear all stock entries to count=0 and cost=0.
REQ-027 Reset mid-transaction SHALL discard the credit with no partial vend.
REQ-028 The block SHALL accept inputs from the first rising clk edge after rst deasserts.

Configuration
REQ-029 With the macro VM_REFUND_EN defined, the block SHALL add a 1-bit input refund.
REQ-030 With VM_REFUND_EN defined, refund=1 in IDLE or COLLECT SHALL take precedence over coins and select, and SHALL next cycle register info=min(balance,255), balance=0, status=00 and the FSM to IDLE.
REQ-031 With VM_REFUND_EN defined, refund SHALL be ignored in other states.
REQ-032 Without VM_REFUND_EN, the block SHALL have no refund port, and credit SHALL leave the block only by vending.

Verification
REQ-033 The bench SHALL write item 3 (count=2, cost=30), insert 25 then 10, and select 3; the required response is status=01, product=3, balance=5, info=1, FSM in COLLECT.
REQ-034 The bench SHALL select item 5 with count=0 while balance=40; the required response is status=10, info=cost of 5, balance=40.
REQ-035 The bench SHALL select item 3 (cost=30) with balance=25; the required response is status=11, info=30, balance=25.
REQ-036 The bench SHALL write item 3 with count=9 during DISPENSE of item 3; the required response is a stored count of 9 and balance reduced by the old cost.
REQ-037 The bench SHALL insert 2622 quarters; the required response is balance saturating at 16'hFFFF.
REQ-038 The bench SHALL drive rst low during CHECK with balance=35; the required response is immediate IDLE, all outputs 0, and no vend after release.
